// File: rtl/y86_branch_predictor.sv
`default_nettype none
// ============================================================================
// y86_branch_predictor : fetch-stage next-PC predictor for the Y86-64 pipeline
// (jXX predictor in three modes, return-address stack, resolution statistics)
// Revision 1.0
// ============================================================================
module y86_branch_predictor #(
  parameter int         PHT_ENTRIES = 64,
  parameter int         RAS_DEPTH   = 8,
  parameter int         MODE        = 2,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [63:0] f_pc,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  input  logic        squash,
  output logic [63:0] f_predPC,
  output logic        f_pred_taken,
  output logic        ret_pred_valid,
  output logic [31:0] pred_count,
  output logic [31:0] mispred_count
);

  localparam int         IDX      = $clog2(PHT_ENTRIES);
  localparam int         PW       = $clog2(RAS_DEPTH);
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

  logic [1:0]  pht_q [PHT_ENTRIES];
  logic [1:0]  pht_d [PHT_ENTRIES];
  logic [63:0] ras_q [RAS_DEPTH];
  logic [63:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [PW:0]   ras_cnt_q, ras_cnt_d;
  logic [31:0]   pred_cnt_q, pred_cnt_d;
  logic [31:0]   mis_cnt_q, mis_cnt_d;

  logic [IDX-1:0] look_idx, upd_idx;
  logic [63:0]    ras_top;
  logic           ras_nonempty, do_push, do_pop, cond_taken;
  logic           unused_pc_bits;

  assign look_idx       = f_pc[IDX-1:0];
  assign upd_idx        = upd_pc[IDX-1:0];
  assign unused_pc_bits = ^{f_pc[63:IDX], upd_pc[63:IDX]};
  // ras_ptr_q names the next free slot, so the top of stack sits one below it
  assign ras_top        = ras_q[ras_ptr_q - 1'b1];
  assign ras_nonempty   = (ras_cnt_q != '0);
  assign do_push        = f_valid && (f_icode == I_CALL);
  assign do_pop         = f_valid && (f_icode == I_RET) && ras_nonempty;

  always_comb begin
    cond_taken = 1'b1;
    if (MODE == 1)      cond_taken = (f_valC < f_valP);
    else if (MODE == 2) cond_taken = pht_q[look_idx][1];
  end

  always_comb begin
    f_predPC       = f_valP;
    f_pred_taken   = 1'b0;
    ret_pred_valid = 1'b0;
    case (f_icode)
      I_JXX: begin
        f_pred_taken = (f_ifun == 4'h0) ? 1'b1 : cond_taken;
        f_predPC     = f_pred_taken ? f_valC : f_valP;
      end
      I_CALL: f_predPC = f_valC;
      I_RET: if (ras_nonempty) begin
        ret_pred_valid = 1'b1;
        f_predPC       = ras_top;
      end
      default: ;
    endcase
  end

  always_comb begin
    pht_d = pht_q;
    if ((MODE == 2) && upd_valid) begin
      if (upd_taken && (pht_q[upd_idx] != 2'b11))
        pht_d[upd_idx] = pht_q[upd_idx] + 2'b01;
      else if (!upd_taken && (pht_q[upd_idx] != 2'b00))
        pht_d[upd_idx] = pht_q[upd_idx] - 2'b01;
    end
  end

  // Squash discards the whole speculative stack, overriding any push/pop
  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (squash) begin
      ras_ptr_d = '0;
      ras_cnt_d = '0;
    end else if (do_push) begin
      ras_d[ras_ptr_q] = f_valP;
      ras_ptr_d        = ras_ptr_q + 1'b1;
      ras_cnt_d        = (ras_cnt_q == RAS_FULL) ? RAS_FULL : ras_cnt_q + 1'b1;
    end else if (do_pop) begin
      ras_ptr_d = ras_ptr_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  always_comb begin
    pred_cnt_d = pred_cnt_q;
    mis_cnt_d  = mis_cnt_q;
    if (upd_valid) begin
      if (pred_cnt_q != 32'hFFFF_FFFF) pred_cnt_d = pred_cnt_q + 32'd1;
      if (upd_mispred && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_INIT;
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      pred_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else begin
      pht_q      <= pht_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      pred_cnt_q <= pred_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  // Stack contents need no reset: they are only read while the count is non-zero
  always_ff @(posedge clock) begin
    ras_q <= ras_d;
  end

  assign pred_count    = pred_cnt_q;
  assign mispred_count = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_branch_predictor.sv
`default_nettype none
// tb_y86_branch_predictor : scoreboard bench for the Y86 branch predictor
// (bimodal/RAS_DEPTH=2 instance plus a BTFN instance sharing the same stimulus)
module tb_y86_branch_predictor;

  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  localparam int S_PC = 0, S_TK = 1, S_RV = 2, S_PCNT = 3, S_MCNT = 4, S_M1PC = 5, S_M1TK = 6;

  logic        clock = 1'b0;
  logic        reset, f_valid, upd_valid, upd_taken, upd_mispred, squash;
  logic [63:0] f_pc, f_valC, f_valP, upd_pc;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] pred_pc, m1_pred_pc;
  logic        pred_tk, ret_v, m1_pred_tk, m1_ret_v;
  logic [31:0] pcnt, mcnt, m1_pcnt, m1_mcnt;

  int checks = 0;
  int failures = 0;
  int m_pred = 0;
  int m_mis = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  y86_branch_predictor #(.PHT_ENTRIES(64), .RAS_DEPTH(2), .MODE(2), .CTR_INIT(2'b01)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispred(upd_mispred), .squash(squash),
    .f_predPC(pred_pc), .f_pred_taken(pred_tk), .ret_pred_valid(ret_v),
    .pred_count(pcnt), .mispred_count(mcnt)
  );

  y86_branch_predictor #(.PHT_ENTRIES(64), .RAS_DEPTH(8), .MODE(1), .CTR_INIT(2'b01)) dut_m1 (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc(f_pc), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispred(upd_mispred), .squash(squash),
    .f_predPC(m1_pred_pc), .f_pred_taken(m1_pred_tk), .ret_pred_valid(m1_ret_v),
    .pred_count(m1_pcnt), .mispred_count(m1_mcnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_PC:    return pred_pc;
      S_TK:    return {63'd0, pred_tk};
      S_RV:    return {63'd0, ret_v};
      S_PCNT:  return {32'd0, pcnt};
      S_MCNT:  return {32'd0, mcnt};
      S_M1PC:  return m1_pred_pc;
      S_M1TK:  return {63'd0, m1_pred_tk};
      default: return 64'hDEAD;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [63:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask

  task automatic expect_counts(input string tag);
    expect_out({tag, "_pcnt"}, S_PCNT, 64'(m_pred));
    expect_out({tag, "_mcnt"}, S_MCNT, 64'(m_mis));
  endtask

  // Compare queued expectations at the falling edge, then advance the counter model
  task automatic step();
    @(negedge clock);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
    if (reset) begin
      m_pred = 0;
      m_mis  = 0;
    end else if (upd_valid) begin
      m_pred++;
      if (upd_mispred) m_mis++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; f_valid = 1'b0; f_pc = '0; f_icode = '0; f_ifun = '0;
    f_valC = '0; f_valP = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_mispred = 1'b0; squash = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] pc,
                       input logic [63:0] valc, input logic [63:0] valp);
    f_valid = 1'b1; f_icode = ic; f_ifun = fn; f_pc = pc; f_valC = valc; f_valP = valp;
  endtask

  task automatic upd(input logic [63:0] pc, input logic tk, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_mispred = mis;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    step();

    // Post-reset: empty stack, zero counters
    idle(); fetch(I_RET, 0, 64'h0, 64'h0, 64'h44);
    expect_out("rst_rv", S_RV, 0); expect_out("rst_ret_pc", S_PC, 64'h44);
    expect_counts("rst");
    step();

    // Bimodal warm-up of index 0x10 (same-cycle lookup sees old value)
    idle(); fetch(I_JXX, 1, 64'h10, 64'h1000, 64'h20); upd(64'h10, 1, 0);
    expect_out("bim_init_tk", S_TK, 0); expect_out("bim_init_pc", S_PC, 64'h20);
    expect_out("btfn_fwd_tk", S_M1TK, 0); expect_out("btfn_fwd_pc", S_M1PC, 64'h20);
    step();
    expect_out("bim_2_tk", S_TK, 1); expect_out("bim_2_pc", S_PC, 64'h1000);
    step();                                         // counter now 3
    expect_out("bim_3_tk", S_TK, 1);
    step();                                         // taken at 3: saturates
    upd(64'h10, 0, 1);
    expect_out("bim_sat3_tk", S_TK, 1);
    step();                                         // 3 -> 2
    expect_out("bim_dec2_tk", S_TK, 1);
    step();                                         // 2 -> 1
    idle(); fetch(I_JXX, 1, 64'h10, 64'h1000, 64'h20);
    expect_out("bim_dec1_tk", S_TK, 0); expect_out("bim_dec1_pc", S_PC, 64'h20);
    expect_counts("bim");
    step();

    // Floor saturation at index 0x20
    for (int i = 0; i < 3; i++) begin
      idle(); fetch(I_JXX, 3, 64'h20, 64'h3000, 64'h28); upd(64'h20, (i == 2), 0);
      expect_out($sformatf("floor_%0d_tk", i), S_TK, 0);
      step();
    end
    idle(); fetch(I_JXX, 3, 64'h20, 64'h3000, 64'h28);
    expect_out("floor_end_tk", S_TK, 0); expect_out("floor_end_pc", S_PC, 64'h28);
    step();

    // Unconditional jump is always taken
    idle(); fetch(I_JXX, 0, 64'h20, 64'h2222, 64'h30);
    expect_out("jmp_tk", S_TK, 1); expect_out("jmp_pc", S_PC, 64'h2222);
    expect_out("jmp_m1_pc", S_M1PC, 64'h2222);
    step();

    // BTFN: backward taken, forward not
    idle(); fetch(I_JXX, 2, 64'h30, 64'h20, 64'h40);
    expect_out("btfn_back_tk", S_M1TK, 1); expect_out("btfn_back_pc", S_M1PC, 64'h20);
    expect_out("bim_back_pc", S_PC, 64'h40);
    step();
    idle(); fetch(I_JXX, 2, 64'h30, 64'h80, 64'h40);
    expect_out("btfn_fwd2_tk", S_M1TK, 0); expect_out("btfn_fwd2_pc", S_M1PC, 64'h40);
    step();

    // Non-control-flow instruction
    idle(); fetch(I_OPQ, 0, 64'h40, 64'h1234, 64'h99);
    expect_out("opq_pc", S_PC, 64'h99); expect_out("opq_tk", S_TK, 0); expect_out("opq_rv", S_RV, 0);
    step();

    // RAS depth 2: third call overwrites the oldest entry
    for (int i = 1; i <= 3; i++) begin
      idle(); fetch(I_CALL, 0, 64'h50, 64'hC00, 64'(i * 256));
      expect_out($sformatf("call_%0d_pc", i), S_PC, 64'hC00);
      step();
    end
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400);
    expect_out("ret1_rv", S_RV, 1); expect_out("ret1_pc", S_PC, 64'h300);
    step();
    expect_out("ret2_rv", S_RV, 1); expect_out("ret2_pc", S_PC, 64'h200);
    step();
    expect_out("ret3_rv", S_RV, 0); expect_out("ret3_pc", S_PC, 64'h400);
    step();

    // Call while fetch not advancing must not push
    idle(); fetch(I_CALL, 0, 64'h70, 64'hC00, 64'h500); f_valid = 1'b0;
    step();
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400);
    expect_out("noval_ret_rv", S_RV, 0);
    step();

    // Squash beats a same-cycle push
    idle(); fetch(I_CALL, 0, 64'h70, 64'hC00, 64'h55); squash = 1'b1;
    expect_out("sq_call_pc", S_PC, 64'hC00);
    step();
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400);
    expect_out("sq_ret_rv", S_RV, 0);
    step();

    // Squash clears existing entries; updates still counted during squash
    idle(); fetch(I_CALL, 0, 64'h70, 64'hC00, 64'h77);
    step();
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400); f_valid = 1'b0;
    expect_out("peek_rv", S_RV, 1); expect_out("peek_pc", S_PC, 64'h77);
    step();
    idle(); squash = 1'b1; upd(64'h8, 1, 1);
    step();
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400);
    expect_out("sq2_ret_rv", S_RV, 0);
    expect_counts("sq2");
    step();

    // Saturate 0x18 and push a call, then reset with everything active
    for (int i = 0; i < 2; i++) begin
      idle(); upd(64'h18, 1, 0);
      step();
    end
    idle(); fetch(I_CALL, 0, 64'h70, 64'hC00, 64'h66);
    step();
    idle(); fetch(I_CALL, 0, 64'h70, 64'hC00, 64'h67); upd(64'h18, 1, 1); squash = 1'b1; reset = 1'b1;
    step();
    idle(); fetch(I_JXX, 1, 64'h18, 64'h1800, 64'h20);
    expect_out("rst2_pht_tk", S_TK, 0);
    expect_counts("rst2");
    step();
    idle(); fetch(I_RET, 0, 64'h60, 64'h0, 64'h400);
    expect_out("rst2_ret_rv", S_RV, 0);
    step();

    // Three mispredicts, then reset clears both counters
    for (int i = 0; i < 3; i++) begin
      idle(); upd(64'h8, 0, 1);
      step();
    end
    idle(); upd(64'h8, 0, 1); reset = 1'b1;
    expect_out("mis3_mcnt", S_MCNT, 3); expect_out("mis3_pcnt", S_PCNT, 3);
    step();
    idle();
    expect_out("mis_rst_mcnt", S_MCNT, 0); expect_out("mis_rst_pcnt", S_PCNT, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
